// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit core's shared datapath.
// Also holds the Z/V/N flag register, evaluates branch conditions and times out stalled memory accesses.
module multicycle_ctrl #(
  parameter int unsigned STALL_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  input  logic        mem_ack,
  input  logic [2:0]  flags_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_ld,
  output logic        pc_ld,
  output logic [1:0]  pc_sel,
  output logic [3:0]  alu_op,
  output logic        alu_src_imm,
  output logic        rf_we,
  output logic [1:0]  rf_wsel,
  output logic [2:0]  flags,
  output logic        halted,
  output logic        err
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [3:0] ALU_NOP = 4'b1100;

  state_t      state_q;
  logic [7:0]  stall_q;
  logic [2:0]  flags_q;
  logic        err_q;
  logic [1:0]  wsel_q;

  logic [3:0]  op;
  logic [2:0]  ccc;
  logic        is_lw;
  logic        is_sw;
  logic        is_mem;
  logic        is_br;
  logic        imm_op;
  logic        cond_true;
  logic        stall_hit;
  logic [3:0]  alu_code;

  assign op     = instr[15:12];
  assign ccc    = instr[11:9];
  assign is_lw  = (op == 4'b1000);
  assign is_sw  = (op == 4'b1001);
  assign is_mem = (op[3:1] == 3'b100);
  assign is_br  = (op[3:1] == 3'b110);
  assign imm_op = op inside {4'b0100, 4'b0101, 4'b0110, 4'b1000, 4'b1001, 4'b1010, 4'b1011};
  assign stall_hit = (stall_q == 8'(STALL_LIMIT - 1));

  // Immediate/register fields belong to the datapath, not to this sequencer.
  logic unused_fields;
  assign unused_fields = ^instr[8:0];

  always_comb begin
    alu_code = ALU_NOP;
    if (!op[3])              alu_code = op;
    else if (is_mem)         alu_code = 4'b1010;
    else if (op == 4'b1010)  alu_code = 4'b1000;
    else if (op == 4'b1011)  alu_code = 4'b1001;
  end

  // Flags are {Z,V,N}; branches look at the register value, never at flags_in.
  always_comb begin
    cond_true = 1'b0;
    case (ccc)
      3'b000: cond_true = !flags_q[2];
      3'b001: cond_true = flags_q[2];
      3'b010: cond_true = !flags_q[2] && !flags_q[0];
      3'b011: cond_true = flags_q[0];
      3'b100: cond_true = flags_q[2] || (!flags_q[2] && !flags_q[0]);
      3'b101: cond_true = flags_q[0] || flags_q[2];
      3'b110: cond_true = flags_q[1];
      default: cond_true = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      stall_q <= 8'd0;
      flags_q <= 3'b000;
      err_q   <= 1'b0;
      wsel_q  <= 2'd0;
    end else begin
      case (state_q)
        S_FETCH, S_MEM: begin
          if (mem_ack) begin
            stall_q <= 8'd0;
            if (state_q == S_FETCH) begin
              state_q <= S_DECODE;
            end else if (is_lw) begin
              wsel_q  <= 2'd1;
              state_q <= S_WB;
            end else begin
              state_q <= S_FETCH;
            end
          end else if (stall_hit) begin
            stall_q <= 8'd0;
            err_q   <= 1'b1;
            state_q <= S_HALT;
          end else begin
            stall_q <= stall_q + 8'd1;
          end
        end
        S_DECODE: begin
          stall_q <= 8'd0;
          state_q <= (op == 4'b1111) ? S_HALT : S_EXEC;
        end
        S_EXEC: begin
          stall_q <= 8'd0;
          case (op)
            4'b0000, 4'b0001:                   flags_q    <= flags_in;
            4'b0010, 4'b0100, 4'b0101, 4'b0110: flags_q[2] <= flags_in[2];
            default: ;
          endcase
          if (is_mem) begin
            state_q <= S_MEM;
          end else if (is_br) begin
            state_q <= S_FETCH;
          end else begin
            wsel_q  <= (op == 4'b1110) ? 2'd2 : 2'd0;
            state_q <= S_WB;
          end
        end
        S_WB: begin
          stall_q <= 8'd0;
          state_q <= S_FETCH;
        end
        S_HALT: state_q <= S_HALT;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_ld        = 1'b0;
    pc_ld        = 1'b0;
    pc_sel       = 2'd0;
    alu_op       = ALU_NOP;
    alu_src_imm  = 1'b0;
    rf_we        = 1'b0;
    rf_wsel      = wsel_q;
    flags        = flags_q;
    halted       = 1'b0;
    err          = err_q;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_ld = 1'b1;
          pc_ld = 1'b1;
        end
      end
      S_EXEC: begin
        alu_op      = alu_code;
        alu_src_imm = imm_op;
        if (is_br && cond_true) begin
          pc_ld  = 1'b1;
          pc_sel = op[0] ? 2'd2 : 2'd1;
        end
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = is_sw;
        alu_op       = alu_code;
        alu_src_imm  = imm_op;
      end
      S_WB:   rf_we  = 1'b1;
      S_HALT: halted = 1'b1;
      default: ;
    endcase
    // An instruction caught by reset must not load or write anything on that edge.
    if (rst) begin
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_ld        = 1'b0;
      pc_ld        = 1'b0;
      pc_sel       = 2'd0;
      alu_op       = ALU_NOP;
      alu_src_imm  = 1'b0;
      rf_we        = 1'b0;
      rf_wsel      = 2'd0;
      flags        = 3'b000;
      halted       = 1'b0;
      err          = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected outputs are queued with the stimulus and compared mid-cycle.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr;
  logic        mem_ack;
  logic [2:0]  flags_in;
  logic        mem_req, mem_we, mem_addr_sel, ir_ld, pc_ld;
  logic [1:0]  pc_sel;
  logic [3:0]  alu_op;
  logic        alu_src_imm, rf_we;
  logic [1:0]  rf_wsel;
  logic [2:0]  flags;
  logic        halted, err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_ld;
    logic       pc_ld;
    logic [1:0] pc_sel;
    logic [3:0] alu_op;
    logic       alu_src_imm;
    logic       rf_we;
    logic [1:0] rf_wsel;
    logic [2:0] flags;
    logic       halted;
    logic       err;
  } obs_t;

  obs_t exp_q[$];
  obs_t care_q[$];
  string tag_q[$];

  always #5 clk = ~clk;

  multicycle_ctrl #(.STALL_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .instr(instr), .mem_ack(mem_ack), .flags_in(flags_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_ld(ir_ld),
    .pc_ld(pc_ld), .pc_sel(pc_sel), .alu_op(alu_op), .alu_src_imm(alu_src_imm),
    .rf_we(rf_we), .rf_wsel(rf_wsel), .flags(flags), .halted(halted), .err(err)
  );

  function automatic obs_t base(input logic [2:0] fl);
    obs_t o;
    o = '0;
    o.alu_op = 4'b1100;
    o.flags  = fl;
    return o;
  endfunction

  function automatic obs_t xr();
    obs_t o;
    o = base(3'b000);
    o.mem_req = 1'b1;
    return o;
  endfunction

  function automatic obs_t xf(input logic ack, input logic [2:0] fl);
    obs_t o;
    o = base(fl);
    o.mem_req = 1'b1;
    o.ir_ld   = ack;
    o.pc_ld   = ack;
    return o;
  endfunction

  function automatic obs_t xd(input logic [2:0] fl);
    return base(fl);
  endfunction

  function automatic obs_t xe(input logic [3:0] aop, input logic imm, input logic pcld,
                              input logic [1:0] psel, input logic [2:0] fl);
    obs_t o;
    o = base(fl);
    o.alu_op      = aop;
    o.alu_src_imm = imm;
    o.pc_ld       = pcld;
    o.pc_sel      = psel;
    return o;
  endfunction

  function automatic obs_t xm(input logic we, input logic [2:0] fl);
    obs_t o;
    o = base(fl);
    o.mem_req      = 1'b1;
    o.mem_addr_sel = 1'b1;
    o.mem_we       = we;
    o.alu_op       = 4'b1010;
    o.alu_src_imm  = 1'b1;
    return o;
  endfunction

  function automatic obs_t xw(input logic [1:0] ws, input logic [2:0] fl);
    obs_t o;
    o = base(fl);
    o.rf_we   = 1'b1;
    o.rf_wsel = ws;
    return o;
  endfunction

  function automatic obs_t xh(input logic [2:0] fl, input logic er);
    obs_t o;
    o = base(fl);
    o.halted = 1'b1;
    o.err    = er;
    return o;
  endfunction

  // One clock of stimulus with its expected outputs; rf_wsel/pc_sel only matter when used.
  task automatic step(input string tag, input logic r, input logic [15:0] ins, input logic ack,
                      input logic [2:0] fin, input obs_t e, input logic req_dc);
    obs_t c, obs, ee, cc;
    string t;
    rst = r; instr = ins; mem_ack = ack; flags_in = fin;
    c = '1;
    if (!e.rf_we && !r) c.rf_wsel = 2'b00;
    if (!e.pc_ld && !r) c.pc_sel  = 2'b00;
    if (req_dc)         c.mem_req = 1'b0;
    exp_q.push_back(e);
    care_q.push_back(c);
    tag_q.push_back(tag);
    @(negedge clk);
    ee = exp_q.pop_front();
    cc = care_q.pop_front();
    t  = tag_q.pop_front();
    obs = {mem_req, mem_we, mem_addr_sel, ir_ld, pc_ld, pc_sel, alu_op, alu_src_imm,
           rf_we, rf_wsel, flags, halted, err};
    checks++;
    assert ((obs & cc) === (ee & cc))
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", t, obs & cc, ee & cc);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic r);
    rst = r; mem_ack = 1'b0; flags_in = 3'b000;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; instr = 16'h0000; mem_ack = 1'b0; flags_in = 3'b000;
    @(posedge clk); #1;
    // Reset held: ack must not load IR while rst is high.
    step("reset",     1, 16'h0000, 1, 3'b000, xr(), 0);

    // ADD: 4 cycles, all flags loaded.
    step("add_f",     0, 16'h0123, 1, 3'b000, xf(1, 3'b000), 0);
    step("add_d",     0, 16'h0123, 0, 3'b000, xd(3'b000), 0);
    step("add_e",     0, 16'h0123, 0, 3'b011, xe(4'b0000, 0, 0, 2'd0, 3'b000), 0);
    step("add_w",     0, 16'h0123, 0, 3'b000, xw(2'd0, 3'b011), 0);
    // SUB clears flags to 000.
    step("sub_f",     0, 16'h1123, 1, 3'b000, xf(1, 3'b011), 0);
    step("sub_d",     0, 16'h1123, 0, 3'b000, xd(3'b011), 0);
    step("sub_e",     0, 16'h1123, 0, 3'b000, xe(4'b0001, 0, 0, 2'd0, 3'b011), 0);
    step("sub_w",     0, 16'h1123, 0, 3'b000, xw(2'd0, 3'b000), 0);
    // B ccc=010 with flags 000: taken, flags_in ignored.
    step("b1_f",      0, 16'hC400, 1, 3'b000, xf(1, 3'b000), 0);
    step("b1_d",      0, 16'hC400, 0, 3'b000, xd(3'b000), 0);
    step("b1_e",      0, 16'hC400, 0, 3'b111, xe(4'b1100, 0, 1, 2'd1, 3'b000), 0);
    // XOR updates Z only.
    step("xor_f",     0, 16'h2345, 1, 3'b000, xf(1, 3'b000), 0);
    step("xor_d",     0, 16'h2345, 0, 3'b000, xd(3'b000), 0);
    step("xor_e",     0, 16'h2345, 0, 3'b111, xe(4'b0010, 0, 0, 2'd0, 3'b000), 0);
    step("xor_w",     0, 16'h2345, 0, 3'b000, xw(2'd0, 3'b100), 0);
    // B ccc=010 with Z=1: not taken.
    step("b2_f",      0, 16'hC400, 1, 3'b000, xf(1, 3'b100), 0);
    step("b2_d",      0, 16'hC400, 0, 3'b000, xd(3'b100), 0);
    step("b2_e",      0, 16'hC400, 0, 3'b000, xe(4'b1100, 0, 0, 2'd0, 3'b100), 0);
    // LW: stray ack in DECODE ignored, three wait cycles in MEM.
    step("lw_f",      0, 16'h8123, 1, 3'b000, xf(1, 3'b100), 0);
    step("lw_d",      0, 16'h8123, 1, 3'b000, xd(3'b100), 0);
    step("lw_e",      0, 16'h8123, 0, 3'b011, xe(4'b1010, 1, 0, 2'd0, 3'b100), 0);
    step("lw_m1",     0, 16'h8123, 0, 3'b000, xm(0, 3'b100), 0);
    step("lw_m2",     0, 16'h8123, 0, 3'b000, xm(0, 3'b100), 0);
    step("lw_m3",     0, 16'h8123, 0, 3'b000, xm(0, 3'b100), 0);
    step("lw_m4",     0, 16'h8123, 1, 3'b000, xm(0, 3'b100), 0);
    step("lw_w",      0, 16'h8123, 0, 3'b000, xw(2'd1, 3'b100), 0);
    // BR ccc=111: always taken via register.
    step("br_f",      0, 16'hDE00, 1, 3'b000, xf(1, 3'b100), 0);
    step("br_d",      0, 16'hDE00, 0, 3'b000, xd(3'b100), 0);
    step("br_e",      0, 16'hDE00, 0, 3'b000, xe(4'b1100, 0, 1, 2'd2, 3'b100), 0);
    // PCS: write back PC+2, flags untouched.
    step("pcs_f",     0, 16'hE000, 1, 3'b000, xf(1, 3'b100), 0);
    step("pcs_d",     0, 16'hE000, 0, 3'b000, xd(3'b100), 0);
    step("pcs_e",     0, 16'hE000, 0, 3'b111, xe(4'b1100, 0, 0, 2'd0, 3'b100), 0);
    step("pcs_w",     0, 16'hE000, 0, 3'b000, xw(2'd2, 3'b100), 0);
    // SW abandoned by reset while MEM is pending.
    step("sw1_f",     0, 16'h9000, 1, 3'b000, xf(1, 3'b100), 0);
    step("sw1_d",     0, 16'h9000, 0, 3'b000, xd(3'b100), 0);
    step("sw1_e",     0, 16'h9000, 0, 3'b000, xe(4'b1010, 1, 0, 2'd0, 3'b100), 0);
    step("sw1_m1",    0, 16'h9000, 0, 3'b000, xm(1, 3'b100), 0);
    step("sw1_m2",    0, 16'h9000, 0, 3'b000, xm(1, 3'b100), 0);
    step("sw1_rst",   1, 16'h9000, 0, 3'b000, xr(), 1);
    // SW zero-wait: 4 cycles then back in FETCH.
    step("sw2_f",     0, 16'h9000, 1, 3'b000, xf(1, 3'b000), 0);
    step("sw2_d",     0, 16'h9000, 0, 3'b000, xd(3'b000), 0);
    step("sw2_e",     0, 16'h9000, 0, 3'b000, xe(4'b1010, 1, 0, 2'd0, 3'b000), 0);
    step("sw2_m",     0, 16'h9000, 1, 3'b000, xm(1, 3'b000), 0);
    step("sw2_next",  0, 16'h9000, 0, 3'b000, xf(0, 3'b000), 0);
    // HLT: halted from cycle 3, acks ignored.
    step("hlt_f",     0, 16'hF000, 1, 3'b000, xf(1, 3'b000), 0);
    step("hlt_d",     0, 16'hF000, 0, 3'b000, xd(3'b000), 0);
    step("hlt_h1",    0, 16'hF000, 1, 3'b000, xh(3'b000, 0), 0);
    step("hlt_h2",    0, 16'hF000, 1, 3'b000, xh(3'b000, 0), 0);
    idle(1);
    // Fetch timeout at STALL_LIMIT=4.
    step("stall_f1",  0, 16'h0000, 0, 3'b000, xf(0, 3'b000), 0);
    step("stall_f2",  0, 16'h0000, 0, 3'b000, xf(0, 3'b000), 0);
    step("stall_f3",  0, 16'h0000, 0, 3'b000, xf(0, 3'b000), 0);
    step("stall_f4",  0, 16'h0000, 0, 3'b000, xf(0, 3'b000), 0);
    step("stall_h1",  0, 16'h0000, 1, 3'b000, xh(3'b000, 1), 0);
    step("stall_h2",  0, 16'h0000, 0, 3'b000, xh(3'b000, 1), 0);
    idle(1);
    step("post_rst",  0, 16'h0000, 0, 3'b000, xf(0, 3'b000), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
